// File: rtl/synth_scaler.sv
// Synth sample scaler: volume shift, offset-binary conversion and a small code FIFO
// that feeds a held DAC code to the sampler on its periodic synth_ready strobe.
module synth_scaler #(
   parameter int IN_WIDTH   = 14,
   parameter int OUT_WIDTH  = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [IN_WIDTH-1:0]             sample_in,
   input  logic                            sample_valid,
   output logic                            sample_ready,
   input  logic [2:0]                      volume,
   input  logic                            mute,
   output logic [OUT_WIDTH-1:0]            scaled_synth_code,
   output logic                            synth_valid,
   input  logic                            synth_ready,
   output logic [$clog2(FIFO_DEPTH)+1-1:0] fifo_count,
   output logic [15:0]                     underflow_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [OUT_WIDTH-1:0] MIDSCALE = OUT_WIDTH'(1) << (OUT_WIDTH - 1);

   // Attenuate, drop the extra input LSBs, then flip the MSB to go offset-binary.
   function automatic logic [OUT_WIDTH-1:0] to_code(input logic signed [IN_WIDTH-1:0] s,
                                                    input logic [2:0] vol);
      logic signed [OUT_WIDTH-1:0] t;
      t = OUT_WIDTH'((s >>> vol) >>> (IN_WIDTH - OUT_WIDTH));
      return {~t[OUT_WIDTH-1], t[OUT_WIDTH-2:0]};
   endfunction

   logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [OUT_WIDTH-1:0] code_q, code_d;
   logic                 valid_q;
   logic [15:0]          uf_q, uf_d;
   logic                 push, pop, empty;

   assign empty        = (count_q == '0);
   assign sample_ready = ~rst & (count_q != CW'(FIFO_DEPTH));
   assign push         = sample_valid & sample_ready;
   assign pop          = synth_ready & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      code_d   = code_q;
      uf_d     = uf_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         code_d   = mute ? MIDSCALE : mem_q[rd_ptr_q];
      end
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      // An empty-FIFO strobe holds the last code and is only counted.
      if (synth_ready && empty && uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         code_q   <= MIDSCALE;
         valid_q  <= 1'b0;
         uf_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         code_q   <= code_d;
         valid_q  <= 1'b1;
         uf_q     <= uf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= to_code(sample_in, volume);
   end

   assign scaled_synth_code = code_q;
   assign synth_valid       = valid_q;
   assign fifo_count        = count_q;
   assign underflow_count   = uf_q;

endmodule

// File: tb/tb_synth_scaler.sv
// Scoreboard bench for synth_scaler: expected codes queued at push, compared at advance.
module tb_synth_scaler;

   logic               clk;
   logic               rst;
   logic signed [13:0] sample_in;
   logic               sample_valid;
   logic               sample_ready;
   logic [2:0]         volume;
   logic               mute;
   logic [9:0]         scaled_synth_code;
   logic               synth_valid;
   logic               synth_ready;
   logic [2:0]         fifo_count;
   logic [15:0]        underflow_count;

   synth_scaler #(.IN_WIDTH(14), .OUT_WIDTH(10), .FIFO_DEPTH(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .sample_in         (sample_in),
      .sample_valid      (sample_valid),
      .sample_ready      (sample_ready),
      .volume            (volume),
      .mute              (mute),
      .scaled_synth_code (scaled_synth_code),
      .synth_valid       (synth_valid),
      .synth_ready       (synth_ready),
      .fifo_count        (fifo_count),
      .underflow_count   (underflow_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int         n_chk = 0;
   int         n_err = 0;
   logic [9:0] exp_q[$];
   logic [9:0] exp_code;
   int         exp_uf;

   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] model_code(input logic signed [13:0] s, input logic [2:0] vol);
      integer x;
      x = s;
      x = x >>> vol;
      x = x >>> 4;
      return 10'(x + 512);
   endfunction

   task automatic step(input logic v, input logic signed [13:0] s, input logic [2:0] vol,
                       input logic strb, input logic m);
      logic acc;
      sample_valid = v;
      sample_in    = s;
      volume       = vol;
      synth_ready  = strb;
      mute         = m;
      #1;
      chk_val("sample_ready", sample_ready, exp_q.size() != 4);
      acc = v && (exp_q.size() != 4);
      if (strb) begin
         if (exp_q.size() != 0) begin
            if (m) void'(exp_q.pop_front());
            exp_code = m ? 10'd512 : exp_q.pop_front();
         end else if (exp_uf < 65535) begin
            exp_uf++;
         end
      end
      if (acc) exp_q.push_back(model_code(s, vol));
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      synth_ready  = 1'b0;
      mute         = 1'b0;
      chk_val("code", scaled_synth_code, exp_code);
      chk_val("fifo_count", fifo_count, exp_q.size());
      chk_val("underflow", underflow_count, exp_uf);
      chk_val("synth_valid", synth_valid, 1);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      sample_valid = 1'b0;
      synth_ready  = 1'b0;
      mute         = 1'b0;
      @(posedge clk);
      #1;
      chk_val("rst_ready", sample_ready, 0);
      chk_val("rst_count", fifo_count, 0);
      chk_val("rst_code", scaled_synth_code, 512);
      chk_val("rst_valid", synth_valid, 0);
      chk_val("rst_uf", underflow_count, 0);
      exp_q.delete();
      exp_code = 10'd512;
      exp_uf   = 0;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sample_in = '0; sample_valid = 1'b0; volume = '0; mute = 1'b0; synth_ready = 1'b0;
      exp_code = 10'd512; exp_uf = 0;

      // Underflow from reset
      do_reset();
      repeat (3) step(0, 0, 0, 1, 0);
      chk_val("uf_three", underflow_count, 3);

      // Basic conversion at volume 0, with idle cycles between strobes
      do_reset();
      step(1, 14'sd0, 0, 0, 0);
      step(1, 14'sd8191, 0, 0, 0);
      step(1, -14'sd8192, 0, 0, 0);
      step(1, -14'sd1, 0, 0, 0);
      chk_val("full4", fifo_count, 4);
      step(0, 0, 0, 1, 0); chk_val("c512", scaled_synth_code, 512);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0); chk_val("c1023", scaled_synth_code, 1023);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0); chk_val("c0", scaled_synth_code, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0); chk_val("c511", scaled_synth_code, 511);
      step(0, 0, 0, 0, 0);

      // Volume attenuation
      step(1, 14'sd8191, 1, 0, 0);
      step(1, 14'sd8191, 7, 0, 0);
      step(0, 0, 0, 1, 0); chk_val("vol1", scaled_synth_code, 767);
      step(0, 0, 0, 1, 0); chk_val("vol7", scaled_synth_code, 515);

      // Same-cycle push and strobe on empty FIFO: underflow, entry stays queued
      step(1, 14'sd4096, 0, 1, 0);
      chk_val("nobypass_cnt", fifo_count, 1);
      step(0, 0, 0, 1, 0); chk_val("nobypass_code", scaled_synth_code, 768);

      // Full FIFO back-pressure
      for (int i = 0; i < 5; i++) step(1, 14'(i * 100), 0, 0, 0);
      chk_val("full_cnt", fifo_count, 4);
      step(1, 14'sd2000, 0, 1, 0); chk_val("full_pop", fifo_count, 3);
      step(1, 14'sd3000, 0, 1, 0); chk_val("pushpop", fifo_count, 3);
      repeat (3) step(0, 0, 0, 1, 0);

      // Mute on advance still pops
      step(1, 14'sd8191, 0, 0, 0);
      step(1, -14'sd8192, 0, 0, 0);
      step(0, 0, 0, 1, 1); chk_val("mute_code", scaled_synth_code, 512);
      chk_val("mute_cnt", fifo_count, 1);
      step(0, 0, 0, 1, 0); chk_val("after_mute", scaled_synth_code, 0);

      // Mixed random traffic including back-to-back strobes
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 14'($urandom), 3'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));

      // Reset mid-operation discards contents
      do_reset();
      repeat (3) step(1, 14'sd5000, 0, 0, 0);
      do_reset();
      step(0, 0, 0, 1, 0); chk_val("uf_after_rst", underflow_count, 1);

      // Saturation of the underflow counter
      for (int i = 0; i < 65540; i++) step(0, 0, 0, 1, 0);
      chk_val("uf_sat", underflow_count, 65535);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/synth_scaler.md
Name: synth_scaler

Overview:
- Upstream feeder for the audio sampler: accepts signed synth samples on a valid/ready handshake.
- Applies a volume attenuation shift and converts each sample to an unsigned offset-binary DAC code.
- Buffers codes in a small FIFO.
- Holds a stable code on scaled_synth_code, advancing only when the sampler's periodic one-cycle synth_ready pulse consumes it. The sampler does not latch the code, so this block must hold it steady.

Parameters:
- IN_WIDTH, 14, width of signed input sample (must be >= OUT_WIDTH)
- OUT_WIDTH, 10, width of unsigned output DAC code
- FIFO_DEPTH, 4, entries in code FIFO (power of 2, >= 2)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sample_in  input  IN_WIDTH  signed two's-complement synth sample
- sample_valid  input  1  sample_in is valid
- sample_ready  output  1  block can accept a sample this cycle
- volume  input  3  attenuation, arithmetic right shift 0..7, sampled at push
- mute  input  1  force midscale on the code advanced at pop
- scaled_synth_code  output  OUT_WIDTH  held unsigned DAC code
- synth_valid  output  1  code is meaningful
- synth_ready  input  1  one-cycle consume/advance strobe from the sampler
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- underflow_count  output  16  saturating count of advance strobes that found the FIFO empty

Behaviour:
- Reset (rst high at posedge):
  - FIFO emptied: fifo_count=0, sample_ready=0 during reset.
  - scaled_synth_code = midscale 2^(OUT_WIDTH-1) (512).
  - synth_valid=0, underflow_count=0.
  - Reset asserted mid-operation discards all FIFO contents with no partial pops.
- After reset:
  - synth_valid=1 from the first cycle after rst deasserts.
  - sample_ready = (fifo_count != FIFO_DEPTH), registered/combinational from count only. It never depends on synth_ready.
- Push: on posedge with sample_valid && sample_ready, write the converted code into the FIFO.
- Conversion (combinational at push), with volume sampled at push:
  - a = sample_in >>> volume (arithmetic, sign-preserving).
  - t = a >>> (IN_WIDTH-OUT_WIDTH), truncated to signed OUT_WIDTH. Range -512..511, so no clipping is needed.
  - code = t with MSB inverted (= t + 512).
- Advance (posedge with synth_ready=1):
  - FIFO non-empty:
    - scaled_synth_code <= (mute ? 512 : FIFO head).
    - Pop one entry. mute never stalls the FIFO.
  - FIFO empty:
    - scaled_synth_code unchanged (hold last code).
    - underflow_count increments, saturating at 65535. No pop.
- Latency:
  - A sample pushed into an empty FIFO at cycle N is visible on scaled_synth_code one cycle after the first synth_ready at cycle >= N+1.
  - There is no same-cycle bypass: push and strobe in the same cycle on an empty FIFO counts as an underflow, and the pushed entry stays queued.
- Simultaneous push and pop:
  - When not full: both occur and fifo_count is unchanged.
  - When full: sample_ready=0, so only the pop occurs.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. fifo_count is the authoritative full/empty source.
- scaled_synth_code changes only on an advance or on reset. It is stable for all cycles between strobes.
- synth_ready pulses arrive at most once per cycle with arbitrary spacing; the block must be correct for back-to-back strobes.

Test Plan:
- Reset, no pushes, 3 synth_ready strobes -> scaled_synth_code=512 throughout, synth_valid=1 after reset, underflow_count=3.
- Push samples 0, 8191, -8192, -1 at volume=0, then 4 strobes -> codes 512, 1023, 0, 511 in order; fifo_count steps 4->0. Code must be held constant between strobes.
- Push 8191 at volume=1 and 8191 at volume=7 -> codes 767 and 515 (8191>>>7=63, 63>>>4=3, 3+512=515).
- Push 5 samples with no strobes -> sample_ready=0 after the 4th, 5th not accepted, fifo_count=4. Then push and strobe in the same cycle -> only the pop occurs, count=3. Next cycle push+strobe -> count stays 3.
- mute=1 during a strobe with head code 1023 -> output 512, fifo_count decrements. mute=0 on the next strobe -> next FIFO entry output.
- Fill FIFO with 3 entries, assert rst for 1 cycle -> fifo_count=0, code=512, underflow_count=0. The next strobe underflows and increments the count to 1.
- Force underflow_count to saturate (65540 empty strobes) -> count holds at 65535.
